// File: rtl/mfm_classify_pkg.sv
// ============================================================================
// Module   : mfm_classify_pkg
// Purpose  : Shared MFM definitions: data-rate thresholds, nominal cell
//            counts, FSM state encodings and the interval classifier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mfm_classify_pkg;

    // FSM encodings shared by every MFM block that tracks a reference edge
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } mfm_state_e;

    typedef enum logic [1:0] {
        SYM_S   = 2'd0,
        SYM_M   = 2'd1,
        SYM_L   = 2'd2,
        SYM_ERR = 2'd3
    } mfm_sym_e;

    // 16 MHz clock, DD 250 kbit/s
    localparam int unsigned MFM_DD_NOM_S = 64;
    localparam int unsigned MFM_DD_NOM_M = 96;
    localparam int unsigned MFM_DD_NOM_L = 128;
    localparam int unsigned MFM_DD_T_MIN = 48;
    localparam int unsigned MFM_DD_T_SM  = 80;
    localparam int unsigned MFM_DD_T_ML  = 112;
    localparam int unsigned MFM_DD_T_MAX = 144;

    // 16 MHz clock, HD 500 kbit/s
    localparam int unsigned MFM_HD_NOM_S = 32;
    localparam int unsigned MFM_HD_NOM_M = 48;
    localparam int unsigned MFM_HD_NOM_L = 64;
    localparam int unsigned MFM_HD_T_MIN = 24;
    localparam int unsigned MFM_HD_T_SM  = 40;
    localparam int unsigned MFM_HD_T_ML  = 56;
    localparam int unsigned MFM_HD_T_MAX = 72;

    function automatic mfm_sym_e mfm_classify_interval(
        input int unsigned n,
        input int unsigned t_min,
        input int unsigned t_sm,
        input int unsigned t_ml,
        input int unsigned t_max
    );
        if (n < t_min)      return SYM_ERR;
        else if (n < t_sm)  return SYM_S;
        else if (n < t_ml)  return SYM_M;
        else if (n < t_max) return SYM_L;
        else                return SYM_ERR;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mfm_edge_detect.sv
// ============================================================================
// Module   : mfm_edge_detect
// Purpose  : Two-flop synchroniser plus history flop; one-cycle pulse on each
//            falling edge of an asynchronous active-low input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mfm_edge_detect (
    input  logic i_Clk,
    input  logic i_Reset_n,
    input  logic i_Pin_n,
    output logic o_Fall
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;

    // Reset to 1 so an idle (high) line never produces a spurious edge
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync1_q <= i_Pin_n;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign o_Fall = hist_q & ~sync2_q;

endmodule

`default_nettype wire

// File: rtl/mfm_classify.sv
// ============================================================================
// Module   : mfm_classify
// Purpose  : Measures flux-edge intervals and emits S/M/L/Error strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mfm_classify
    import mfm_classify_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned T_MIN = MFM_DD_T_MIN,
    parameter int unsigned T_SM  = MFM_DD_T_SM,
    parameter int unsigned T_ML  = MFM_DD_T_ML,
    parameter int unsigned T_MAX = MFM_DD_T_MAX
) (
    input  logic             i_Clk,
    input  logic             i_Reset_n,
    input  logic             i_Flux_n,
    output logic             o_S,
    output logic             o_M,
    output logic             o_L,
    output logic             o_Error,
    output logic [CNT_W-1:0] o_Interval
);

    localparam logic [CNT_W-1:0] C_T_MAX = CNT_W'(T_MAX);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    logic             w_fall;
    mfm_sym_e         w_sym;

    mfm_state_e       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] interval_q, interval_d;
    logic             s_q,   s_d;
    logic             m_q,   m_d;
    logic             l_q,   l_d;
    logic             err_q, err_d;

    mfm_edge_detect u_edge (
        .i_Clk     (i_Clk),
        .i_Reset_n (i_Reset_n),
        .i_Pin_n   (i_Flux_n),
        .o_Fall    (w_fall)
    );

    assign w_sym = mfm_classify_interval(32'(cnt_q), T_MIN, T_SM, T_ML, T_MAX);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        interval_d = interval_q;
        s_d        = 1'b0;
        m_d        = 1'b0;
        l_d        = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_fall) begin
                    cnt_d   = C_ONE;
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                // Timeout is checked first so a coincident edge is dropped
                if (cnt_q == C_T_MAX) begin
                    err_d      = 1'b1;
                    interval_d = C_T_MAX;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end else if (w_fall) begin
                    interval_d = cnt_q;
                    cnt_d      = C_ONE;
                    case (w_sym)
                        SYM_S:   s_d   = 1'b1;
                        SYM_M:   m_d   = 1'b1;
                        SYM_L:   l_d   = 1'b1;
                        default: err_d = 1'b1;
                    endcase
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            interval_q <= '0;
            s_q        <= 1'b0;
            m_q        <= 1'b0;
            l_q        <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            interval_q <= interval_d;
            s_q        <= s_d;
            m_q        <= m_d;
            l_q        <= l_d;
            err_q      <= err_d;
        end
    end

    assign o_S        = s_q;
    assign o_M        = m_q;
    assign o_L        = l_q;
    assign o_Error    = err_q;
    assign o_Interval = interval_q;

endmodule

`default_nettype wire

// File: tb/tb_mfm_classify.sv
// ============================================================================
// Module   : tb_mfm_classify
// Purpose  : Scoreboard bench for mfm_classify (DD default thresholds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mfm_classify;
    import mfm_classify_pkg::*;

    localparam int P = 10;

    localparam logic [3:0] C_S   = 4'b0001;
    localparam logic [3:0] C_M   = 4'b0010;
    localparam logic [3:0] C_L   = 4'b0100;
    localparam logic [3:0] C_ERR = 4'b1000;
    localparam logic [3:0] C_NONE = 4'b0000;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       flux_n = 1'b1;
    logic       o_S, o_M, o_L, o_Error;
    logic [7:0] o_Interval;

    typedef struct {
        logic [3:0]  code;
        int unsigned ival;
        longint      t;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    longint last_fall = 0;

    mfm_classify dut (
        .i_Clk      (clk),
        .i_Reset_n  (rst_n),
        .i_Flux_n   (flux_n),
        .o_S        (o_S),
        .o_M        (o_M),
        .o_L        (o_L),
        .o_Error    (o_Error),
        .o_Interval (o_Interval)
    );

    always #(P/2) clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [3:0] code, input int unsigned ival, input longint t);
        exp_t e;
        e.code = code;
        e.ival = ival;
        e.t    = t;
        sb.push_back(e);
    endtask

    // Next falling edge driven `gap` cycles after the previous one; strobe due 3 cycles later
    task automatic fall(input int gap, input logic [3:0] code, input int unsigned ival);
        for (int k = 0; k < gap; k++) begin
            @(negedge clk);
            if (k == gap - 1) begin
                flux_n    = 1'b0;
                last_fall = $time;
                if (code != C_NONE) push_exp(code, ival, $time + 3 * P);
            end else begin
                flux_n = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            flux_n = 1'b1;
        end
    endtask

    // Timeout fires with the counter at 144, 147 cycles after the reference pulse
    task automatic expect_timeout();
        push_exp(C_ERR, 144, last_fall + 147 * P);
    endtask

    always @(negedge clk) begin
        logic [3:0] code;
        exp_t       e;
        code = {o_Error, o_L, o_M, o_S};
        if (code != C_NONE) begin
            check_eq("onehot", $countones(code), 1);
            if (sb.size() == 0) begin
                check_eq("unexpected_strobe", code, C_NONE);
            end else begin
                e = sb.pop_front();
                check_eq("sym", code, e.code);
                check_eq("interval", o_Interval, e.ival);
                check_eq("strobe_time", $time, e.t);
            end
        end
    end

    initial begin
        // Reset: all outputs low
        rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_eq("rst_out", {o_S, o_M, o_L, o_Error, o_Interval}, 0);
        end
        rst_n = 1'b1;
        idle(5);

        // First edge is silent and arms MEASURE
        fall(5, C_NONE, 0);
        idle(3);
        check_eq("state_measure", dut.state_q, ST_MEASURE);

        // Nominal stream
        fall(61, C_S, 64);
        fall(96, C_M, 96);
        fall(128, C_L, 128);

        // Boundaries
        fall(47,  C_ERR, 47);
        fall(48,  C_S,   48);
        fall(79,  C_S,   79);
        fall(80,  C_M,   80);
        fall(111, C_M,   111);
        fall(112, C_L,   112);
        fall(143, C_L,   143);

        // Timeout, silent re-arm, then normal
        expect_timeout();
        idle(200);
        check_eq("state_idle", dut.state_q, ST_IDLE);
        fall(5, C_NONE, 0);
        fall(64, C_S, 64);

        // Glitch inside a 64-cycle stream
        fall(64, C_S,   64);
        fall(10, C_ERR, 10);
        fall(54, C_S,   54);
        fall(64, C_S,   64);

        // Mid-interval reset discards the measurement
        fall(64, C_S, 64);
        idle(50);
        rst_n = 1'b0;
        idle(3);
        check_eq("rst_mid_out", {o_S, o_M, o_L, o_Error}, 0);
        rst_n = 1'b1;
        idle(10);
        fall(5, C_NONE, 0);
        fall(96, C_M, 96);

        // LMLM sync pattern
        fall(128, C_L, 128);
        fall(96,  C_M, 96);
        fall(128, C_L, 128);
        fall(96,  C_M, 96);

        expect_timeout();
        idle(200);
        check_eq("sb_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
